// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the MEM/WB writeback
//   path and a long-latency unit (LU). Pipeline writes win. LU results are
//   queued in a DEPTH-entry FIFO. A head entry that keeps losing to the
//   pipeline forces a one-cycle pipeline stall so that it can drain.
//
// Ports
//   clk_i, rst_ni        clock (rising edge) / async active-low reset
//   wb_*_i               MEM/WB writeback request (data muxed by wb_memtoreg_i)
//   lu_valid_i/_rd_i/_data_i, lu_ready_o   LU result handshake
//   stall_pipe_o         registered; pipeline holds MEM/WB while high
//   rf_we_o/_waddr_o/_wdata_o              registered write port
//   lu_pending_o         FIFO occupancy
//
// state  | meaning
// IDLE   | FIFO empty, wait counter cleared
// PEND   | FIFO holds entries; head waits for a free port cycle
// FORCE  | stall_pipe high for this cycle; head is written unconditionally
module wb_port_arbiter #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [31:0]              wb_memdata_i,
   input  logic [31:0]              wb_alures_i,
   input  logic [4:0]               wb_rd_i,
   input  logic                     wb_regwrite_i,
   input  logic                     wb_memtoreg_i,
   input  logic                     lu_valid_i,
   output logic                     lu_ready_o,
   input  logic [4:0]               lu_rd_i,
   input  logic [31:0]              lu_data_i,
   output logic                     stall_pipe_o,
   output logic                     rf_we_o,
   output logic [4:0]               rf_waddr_o,
   output logic [31:0]              rf_wdata_o,
   output logic [$clog2(DEPTH):0]   lu_pending_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [7:0]    WAIT_LAST = 8'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_FORCE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [7:0]      wait_q, wait_d;
   logic            stall_q, stall_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic            rf_we_q;
   logic [4:0]      rf_waddr_q;
   logic [31:0]     rf_wdata_q;

   logic [4:0]      fifo_rd_mem  [DEPTH];
   logic [31:0]     fifo_dat_mem [DEPTH];

   logic            fifo_ne;
   logic            pipe_req;
   logic            push;
   logic            pop;
   logic            grant_pipe;
   logic [31:0]     wb_data;

   assign fifo_ne    = (count_q != '0);
   assign lu_ready_o = (count_q != CNT_FULL);
   assign push       = lu_valid_i && lu_ready_o;
   // wb_* inputs are stale while stalled; the pipeline re-presents them.
   assign pipe_req   = wb_regwrite_i && (wb_rd_i != 5'd0) && !stall_q;
   assign wb_data    = wb_memtoreg_i ? wb_memdata_i : wb_alures_i;

   always_comb begin
      pop        = 1'b0;
      grant_pipe = 1'b0;
      if (stall_q && fifo_ne) begin
         pop = 1'b1;
      end else if (pipe_req) begin
         grant_pipe = 1'b1;
      end else if (fifo_ne) begin
         pop = 1'b1;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      stall_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            wait_d = '0;
            if (push) state_d = ST_PEND;
         end
         ST_PEND: begin
            if (pop) begin
               wait_d = '0;
               if (count_d == '0) state_d = ST_IDLE;
            end else if (grant_pipe) begin
               if (wait_q >= WAIT_LAST) begin
                  stall_d = 1'b1;
                  wait_d  = '0;
                  state_d = ST_FORCE;
               end else if (wait_q != 8'hFF) begin
                  wait_d = wait_q + 8'd1;
               end
            end
         end
         ST_FORCE: begin
            wait_d  = '0;
            state_d = (count_d != '0) ? ST_PEND : ST_IDLE;
         end
         default: begin
            wait_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         wait_q     <= '0;
         stall_q    <= 1'b0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         stall_q  <= stall_d;
         count_q  <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         rf_we_q <= pop || grant_pipe;
         if (pop) begin
            rf_waddr_q <= fifo_rd_mem[rd_ptr_q];
            rf_wdata_q <= fifo_dat_mem[rd_ptr_q];
         end else if (grant_pipe) begin
            rf_waddr_q <= wb_rd_i;
            rf_wdata_q <= wb_data;
         end
      end
   end

   // Storage needs no reset: count/pointers alone decide what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_rd_mem[wr_ptr_q]  <= lu_rd_i;
         fifo_dat_mem[wr_ptr_q] <= lu_data_i;
      end
   end

   assign stall_pipe_o = stall_q;
   assign rf_we_o      = rf_we_q;
   assign rf_waddr_o   = rf_waddr_q;
   assign rf_wdata_o   = rf_wdata_q;
   assign lu_pending_o = count_q;

endmodule
